// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that shares the register-file write port between the ALU (A)
// and load (B) writeback paths, with a pending-write scoreboard for RAW stalls.
module reg_write_arbiter #(
    parameter int W       = 8,
    parameter int D       = 3,
    parameter bit ZERO_RO = 1'b0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              ValidA,
    input  logic [D-1:0]      AddrA,
    input  logic [W-1:0]      DataA,
    output logic              ReadyA,
    input  logic              ValidB,
    input  logic [D-1:0]      AddrB,
    input  logic [W-1:0]      DataB,
    output logic              ReadyB,
    input  logic              Claim,
    input  logic [D-1:0]      ClaimAddr,
    output logic              WriteEn,
    output logic [D-1:0]      Waddr,
    output logic [W-1:0]      DataIn,
    output logic [2**D-1:0]   PendingMask
);

    localparam int   R     = 2**D;
    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

    logic         ptr;
    logic         we_q;
    logic         drop_q;
    logic [D-1:0] waddr_q;
    logic [W-1:0] data_q;
    logic [R-1:0] pend_q;
    logic [R-1:0] pend_next;

    logic         grant_a;
    logic         grant_b;
    logic         grant_any;
    logic         contended;
    logic         grant_zero;
    logic [D-1:0] grant_addr;
    logic [W-1:0] grant_data;

    always_comb begin
        contended  = ValidA & ValidB;
        grant_a    = Reset_n & ValidA & (~ValidB | (ptr == PTR_A));
        grant_b    = Reset_n & ValidB & (~ValidA | (ptr == PTR_B));
        grant_any  = grant_a | grant_b;
        grant_addr = grant_a ? AddrA : AddrB;
        grant_data = grant_a ? DataA : DataB;
        grant_zero = ZERO_RO && (grant_addr == '0);
    end

    assign ReadyA = grant_a;
    assign ReadyB = grant_b;

    // Commit/drop clears first, then a same-cycle claim re-sets the bit (claim wins).
    always_comb begin
        pend_next = pend_q;
        if (we_q)
            pend_next[waddr_q] = 1'b0;
        if (drop_q)
            pend_next[0] = 1'b0;
        if (Claim)
            pend_next[ClaimAddr] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ptr     <= PTR_A;
            we_q    <= 1'b0;
            drop_q  <= 1'b0;
            waddr_q <= '0;
            data_q  <= '0;
            pend_q  <= '0;
        end else begin
            we_q   <= grant_any & ~grant_zero;
            drop_q <= grant_any & grant_zero;
            if (grant_any && !grant_zero) begin
                waddr_q <= grant_addr;
                data_q  <= grant_data;
            end
            if (contended)
                ptr <= ~ptr;
            pend_q <= pend_next;
        end
    end

    // Gating with Reset_n keeps a write staged before reset from reaching RegFile
    // during the reset cycle itself.
    assign WriteEn     = Reset_n & we_q;
    assign Waddr       = Reset_n ? waddr_q : '0;
    assign DataIn      = Reset_n ? data_q  : '0;
    assign PendingMask = Reset_n ? pend_q  : '0;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: one instance with ZERO_RO=0 and one with
// ZERO_RO=1 share stimulus; a small RegFile model sits behind each write port.
module tb_reg_write_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_a, valid_b, claim;
    logic [2:0] addr_a, addr_b, claim_addr;
    logic [7:0] data_a, data_b;

    logic       ready_a, ready_b, write_en;
    logic [2:0] waddr;
    logic [7:0] data_in, pending;
    logic       ready_a_z, ready_b_z, write_en_z;
    logic [2:0] waddr_z;
    logic [7:0] data_in_z, pending_z;

    logic       rf_init;
    logic [7:0] rf0 [8];
    logic [7:0] rfz [8];

    int checks = 0;
    int errors = 0;

    int exp_addr [4] = '{1, 2, 4, 6};
    int exp_data [4] = '{'hA1, 'hB2, 'hA4, 'hB6};

    always #5 clk = ~clk;

    reg_write_arbiter #(.W(8), .D(3), .ZERO_RO(1'b0)) u_dut (
        .Clk(clk), .Reset_n(rst_n),
        .ValidA(valid_a), .AddrA(addr_a), .DataA(data_a), .ReadyA(ready_a),
        .ValidB(valid_b), .AddrB(addr_b), .DataB(data_b), .ReadyB(ready_b),
        .Claim(claim), .ClaimAddr(claim_addr),
        .WriteEn(write_en), .Waddr(waddr), .DataIn(data_in), .PendingMask(pending)
    );

    reg_write_arbiter #(.W(8), .D(3), .ZERO_RO(1'b1)) u_dut_z (
        .Clk(clk), .Reset_n(rst_n),
        .ValidA(valid_a), .AddrA(addr_a), .DataA(data_a), .ReadyA(ready_a_z),
        .ValidB(valid_b), .AddrB(addr_b), .DataB(data_b), .ReadyB(ready_b_z),
        .Claim(claim), .ClaimAddr(claim_addr),
        .WriteEn(write_en_z), .Waddr(waddr_z), .DataIn(data_in_z), .PendingMask(pending_z)
    );

    // RegFile models: commit on the edge that ends a WriteEn=1 cycle; no reset.
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 8; i++) begin
                rf0[i] <= '0;
                rfz[i] <= '0;
            end
        end else begin
            if (write_en)   rf0[waddr]   <= data_in;
            if (write_en_z) rfz[waddr_z] <= data_in_z;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rf_init = 1'b1;
        valid_a = 1'b1; addr_a = 3'd1; data_a = 8'h11;
        valid_b = 1'b0; addr_b = '0; data_b = '0;
        claim = 1'b0; claim_addr = '0;

        // 1: reset holds everything quiet even with A valid
        tick(); tick();
        check("rst_ready_a", 32'(ready_a), 0);
        check("rst_ready_b", 32'(ready_b), 0);
        check("rst_ready_a_z", 32'(ready_a_z), 0);
        check("rst_ready_b_z", 32'(ready_b_z), 0);
        check("rst_write_en", 32'(write_en), 0);
        check("rst_waddr", 32'(waddr), 0);
        check("rst_data_in", 32'(data_in), 0);
        check("rst_pending", 32'(pending), 0);
        rf_init = 1'b0; rst_n = 1'b1; valid_a = 1'b0;
        tick();

        // 2: A only
        valid_a = 1'b1; addr_a = 3'd3; data_a = 8'h5A;
        #1;
        check("a_only_ready_a", 32'(ready_a), 1);
        check("a_only_ready_b", 32'(ready_b), 0);
        tick();
        valid_a = 1'b0;
        check("a_only_we", 32'(write_en), 1);
        check("a_only_waddr", 32'(waddr), 3);
        check("a_only_data", 32'(data_in), 'h5A);
        tick();
        check("a_only_we_off", 32'(write_en), 0);
        check("a_only_waddr_hold", 32'(waddr), 3);
        check("a_only_data_hold", 32'(data_in), 'h5A);
        check("a_only_rf3", 32'(rf0[3]), 'h5A);

        // 3: contention alternates A,B,A,B with back-to-back writes
        valid_a = 1'b1; addr_a = 3'd1; data_a = 8'hA1;
        valid_b = 1'b1; addr_b = 3'd2; data_b = 8'hB2;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("cont_ready_a_%0d", k), 32'(ready_a), (k % 2 == 0) ? 1 : 0);
            check($sformatf("cont_ready_b_%0d", k), 32'(ready_b), (k % 2 == 0) ? 0 : 1);
            tick();
            check($sformatf("cont_we_%0d", k), 32'(write_en), 1);
            check($sformatf("cont_waddr_%0d", k), 32'(waddr), 32'(exp_addr[k]));
            check($sformatf("cont_data_%0d", k), 32'(data_in), 32'(exp_data[k]));
            case (k)
                0: begin addr_a = 3'd4; data_a = 8'hA4; end
                1: begin addr_b = 3'd6; data_b = 8'hB6; end
                2: begin addr_a = 3'd7; data_a = 8'hA7; end
                default: ;
            endcase
        end
        valid_a = 1'b0; valid_b = 1'b0;
        tick();
        check("cont_we_off", 32'(write_en), 0);
        check("cont_rf1", 32'(rf0[1]), 'hA1);
        check("cont_rf2", 32'(rf0[2]), 'hB2);
        check("cont_rf4", 32'(rf0[4]), 'hA4);
        check("cont_rf6", 32'(rf0[6]), 'hB6);

        // 4: scoreboard
        claim = 1'b1; claim_addr = 3'd5;
        tick();
        claim = 1'b0;
        check("sb_claim5", 32'(pending), 'h20);
        valid_b = 1'b1; addr_b = 3'd5; data_b = 8'h55;
        #1;
        check("sb_ready_b", 32'(ready_b), 1);
        tick();
        valid_b = 1'b0;
        check("sb_we", 32'(write_en), 1);
        check("sb_pending_before_commit", 32'(pending), 'h20);
        tick();
        check("sb_pending_cleared", 32'(pending), 0);
        check("sb_rf5", 32'(rf0[5]), 'h55);

        claim = 1'b1; claim_addr = 3'd5;
        tick();
        claim = 1'b0;
        valid_b = 1'b1; addr_b = 3'd5; data_b = 8'h66;
        tick();
        valid_b = 1'b0;
        claim = 1'b1; claim_addr = 3'd5;
        tick();
        claim = 1'b0;
        check("sb_claim_wins", 32'(pending), 'h20);
        check("sb_rf5_second", 32'(rf0[5]), 'h66);
        claim = 1'b1; claim_addr = 3'd5;
        tick();
        claim = 1'b0;
        check("sb_reclaim", 32'(pending), 'h20);
        valid_a = 1'b1; addr_a = 3'd2; data_a = 8'h22;
        tick();
        valid_a = 1'b0;
        tick();
        check("sb_nonpending_commit", 32'(pending), 'h20);
        check("sb_rf2", 32'(rf0[2]), 'h22);
        valid_a = 1'b1; addr_a = 3'd5; data_a = 8'h77;
        tick();
        valid_a = 1'b0;
        tick();
        check("sb_final_clear", 32'(pending), 0);

        // 5: address 0 with ZERO_RO=1 handshakes but is dropped
        claim = 1'b1; claim_addr = 3'd0;
        tick();
        claim = 1'b0;
        check("z_claim0", 32'(pending), 'h01);
        check("z_claim0_z", 32'(pending_z), 'h01);
        valid_a = 1'b1; addr_a = 3'd0; data_a = 8'hFF;
        #1;
        check("z_ready_a", 32'(ready_a), 1);
        check("z_ready_a_z", 32'(ready_a_z), 1);
        tick();
        valid_a = 1'b0;
        check("z_we_normal", 32'(write_en), 1);
        check("z_we_dropped", 32'(write_en_z), 0);
        check("z_pending_z_held", 32'(pending_z), 'h01);
        tick();
        check("z_pending_z_cleared", 32'(pending_z), 0);
        check("z_pending_cleared", 32'(pending), 0);
        check("z_rfz0", 32'(rfz[0]), 0);
        check("z_rf0", 32'(rf0[0]), 'hFF);

        // 6: reset with a staged write
        valid_a = 1'b1; addr_a = 3'd7; data_a = 8'h77;
        valid_b = 1'b1; addr_b = 3'd3; data_b = 8'h33;
        #1;
        check("mid_ready_a", 32'(ready_a), 1);
        check("mid_ready_b", 32'(ready_b), 0);
        tick();
        valid_a = 1'b0; valid_b = 1'b0; rst_n = 1'b0;
        #1;
        check("mid_we", 32'(write_en), 0);
        check("mid_waddr", 32'(waddr), 0);
        check("mid_data", 32'(data_in), 0);
        tick();
        check("mid_rf7", 32'(rf0[7]), 0);
        check("mid_rf3", 32'(rf0[3]), 'h5A);
        rst_n = 1'b1;
        valid_a = 1'b1; addr_a = 3'd1; data_a = 8'h01;
        valid_b = 1'b1; addr_b = 3'd2; data_b = 8'h02;
        #1;
        check("post_rst_ready_a", 32'(ready_a), 1);
        check("post_rst_ready_b", 32'(ready_b), 0);
        tick();
        valid_a = 1'b0; valid_b = 1'b0;
        check("post_rst_we", 32'(write_en), 1);
        check("post_rst_waddr", 32'(waddr), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
